// File: rtl/scoreboard_pkg.sv
// Shared definitions for the scoreboard: status encoding and the status transition rule.
package scoreboard_pkg;

    localparam int STATUS_W = 2;

    typedef enum logic [STATUS_W-1:0] {
        ST_IDLE = 2'b00,
        ST_PASS = 2'b01,
        ST_FAIL = 2'b10
    } status_e;

    // FAIL is absorbing; a match only promotes IDLE to PASS.
    function automatic status_e next_status(input status_e cur, input logic cmp, input logic mismatch);
        status_e nxt;
        nxt = cur;
        if (cur == ST_FAIL) begin
            nxt = ST_FAIL;
        end else if (cmp && mismatch) begin
            nxt = ST_FAIL;
        end else if (cmp) begin
            nxt = ST_PASS;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// Expected-word queue for the scoreboard; head word is presented combinationally on rdata.
module sb_fifo #(
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATAWIDTH-1:0]     wdata,
    output logic [DATAWIDTH-1:0]     rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] LVL_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_EMPTY = {(AW+1){1'b0}};

    logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
    logic [DATAWIDTH-1:0] mem_q [DEPTH];
    logic                 do_push_s, do_pop_s;

    // Pointers carry one extra bit so their difference spans 0..DEPTH.
    assign level = wr_q - rd_q;
    assign full  = (level == LVL_FULL);
    assign empty = (level == LVL_EMPTY);
    assign rdata = mem_q[rd_q[AW-1:0]];

    // A pop frees the slot in the same cycle, so a push at full is still taken.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        wr_d      = wr_q;
        rd_d      = rd_q;
        if (do_push_s) begin
            wr_d = wr_q + PTR_ONE;
        end else begin
            wr_d = wr_q;
        end
        if (do_pop_s) begin
            rd_d = rd_q + PTR_ONE;
        end else begin
            rd_d = rd_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= {(AW+1){1'b0}};
            rd_q <= {(AW+1){1'b0}};
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array; contents are only observed while occupied, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/scoreboard.sv
// In-order scoreboard: queues expected words, compares them against measured words,
// and reports registered match/mismatch counts, status and first-failure capture.
module scoreboard
    import scoreboard_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 8,
    parameter int CNTWIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     exp_valid,
    input  logic [DATAWIDTH-1:0]     exp_data,
    input  logic                     act_valid,
    input  logic [DATAWIDTH-1:0]     act_data,
    output logic                     err,
    output logic [STATUS_W-1:0]      status,
    output logic [CNTWIDTH-1:0]      match_cnt,
    output logic [CNTWIDTH-1:0]      err_cnt,
    output logic [DATAWIDTH-1:0]     fail_exp,
    output logic [DATAWIDTH-1:0]     fail_act,
    output logic                     ovf,
    output logic                     unf,
    output logic [$clog2(DEPTH):0]   level
);

    localparam logic [CNTWIDTH-1:0] CNT_MAX = {CNTWIDTH{1'b1}};
    localparam logic [CNTWIDTH-1:0] CNT_ONE = {{(CNTWIDTH-1){1'b0}}, 1'b1};

    logic                 full_s, empty_s, pop_s, mismatch_s;
    logic [DATAWIDTH-1:0] head_s;

    logic                 err_q, err_d;
    status_e              status_q, status_d;
    logic [CNTWIDTH-1:0]  match_cnt_q, match_cnt_d, err_cnt_q, err_cnt_d;
    logic [DATAWIDTH-1:0] fail_exp_q, fail_exp_d, fail_act_q, fail_act_d;
    logic                 ovf_q, ovf_d, unf_q, unf_d;

    sb_fifo #(
        .DATAWIDTH (DATAWIDTH),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (exp_valid),
        .pop   (pop_s),
        .wdata (exp_data),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level)
    );

    assign pop_s      = act_valid && !empty_s;
    assign mismatch_s = (head_s != act_data);

    // Next-state for compare results, saturating counters, sticky flags and status.
    always_comb begin
        err_d       = pop_s && mismatch_s;
        match_cnt_d = match_cnt_q;
        err_cnt_d   = err_cnt_q;
        fail_exp_d  = fail_exp_q;
        fail_act_d  = fail_act_q;
        ovf_d       = ovf_q || (exp_valid && full_s && !pop_s);
        unf_d       = unf_q || (act_valid && empty_s);
        status_d    = next_status(status_q, pop_s, mismatch_s);
        if (pop_s && !mismatch_s && (match_cnt_q != CNT_MAX)) begin
            match_cnt_d = match_cnt_q + CNT_ONE;
        end else begin
            match_cnt_d = match_cnt_q;
        end
        if (pop_s && mismatch_s && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
        end else begin
            err_cnt_d = err_cnt_q;
        end
        // FAIL is terminal, so not-yet-FAIL marks the first mismatch since reset.
        if (pop_s && mismatch_s && (status_q != ST_FAIL)) begin
            fail_exp_d = head_s;
            fail_act_d = act_data;
        end else begin
            fail_exp_d = fail_exp_q;
            fail_act_d = fail_act_q;
        end
    end

    // Result registers and status FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q       <= 1'b0;
            status_q    <= ST_IDLE;
            match_cnt_q <= {CNTWIDTH{1'b0}};
            err_cnt_q   <= {CNTWIDTH{1'b0}};
            fail_exp_q  <= {DATAWIDTH{1'b0}};
            fail_act_q  <= {DATAWIDTH{1'b0}};
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            err_q       <= err_d;
            status_q    <= status_d;
            match_cnt_q <= match_cnt_d;
            err_cnt_q   <= err_cnt_d;
            fail_exp_q  <= fail_exp_d;
            fail_act_q  <= fail_act_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign err       = err_q;
    assign status    = status_q;
    assign match_cnt = match_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign fail_exp  = fail_exp_q;
    assign fail_act  = fail_act_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: doc/scoreboard.md
SCOREBOARD -- requirements
Module: scoreboard

Interface
REQ-001 Parameter DATAWIDTH, 32, width of expected and measured data words.
REQ-002 Parameter DEPTH, 8, expected-value queue depth (power of 2, >=2).
REQ-003 Parameter CNTWIDTH, 16, width of match and error counters.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-006 exp_valid  in  1  expected word present this cycle (from reference model).
REQ-007 exp_data  in  DATAWIDTH  expected word.
REQ-008 act_valid  in  1  measured word present this cycle (from DUT output).
REQ-009 act_data  in  DATAWIDTH  measured word.
REQ-010 err  out  1  one-cycle pulse, mismatch detected on previous compare.
REQ-011 status  out  2  00 IDLE, 01 PASS, 10 FAIL.
REQ-012 match_cnt  out  CNTWIDTH  number of matching compares.
REQ-013 err_cnt  out  CNTWIDTH  number of mismatching compares.
REQ-014 fail_exp / fail_act  out  DATAWIDTH each  expected/measured words of first mismatch.
REQ-015 ovf / unf  out  1 each  sticky queue overflow / underflow flags.
REQ-016 level  out  clog2(DEPTH)+1  current queue occupancy.

Function
REQ-017 Expected words SHALL be queued in order; push when exp_valid=1 and queue not full at the clock edge.
REQ-018 A compare SHALL occur when act_valid=1 and queue non-empty: head popped and compared with act_data in that cycle.
REQ-019 Compare result SHALL appear one cycle after the compare: err, counters, status, fail capture all registered.
REQ-020 exp_valid=1 with queue full and no pop SHALL drop the word and set ovf.
REQ-021 Simultaneous push and pop with queue full SHALL accept the push; ovf not set; level unchanged.
REQ-022 act_valid=1 with queue empty SHALL set unf, perform no compare, leave counters unchanged; a simultaneous push is stored normally (no bypass).
REQ-023 Counters SHALL saturate at all-ones; no wrap-around.
REQ-024 Status FSM: IDLE->PASS on first match; IDLE or PASS->FAIL on any mismatch; PASS stays PASS on match; FAIL terminal until reset.
REQ-025 fail_exp/fail_act SHALL capture only the first mismatch after reset; later mismatches do not overwrite.
REQ-026 Queue pointers SHALL wrap modulo DEPTH; level = write count minus read count, range 0..DEPTH.

Reset
REQ-027 rst=0 SHALL asynchronously clear queue (level=0), err=0, status=IDLE, both counters=0, fail_exp=fail_act=0, ovf=unf=0.
REQ-028 Reset asserted mid-operation SHALL discard queued words and any in-flight compare result; no err pulse after release.
REQ-029 First push/compare SHALL be accepted on the first rising edge with rst=1.

Structure
REQ-030 Status encodings (IDLE/PASS/FAIL) and their width SHALL live in a shared package scoreboard_pkg used by RTL and bench.
REQ-031 Queue SHALL be a separate sub-module sb_fifo (DATAWIDTH, DEPTH; push, pop, full, empty, level); compare/count/FSM logic in scoreboard.

Verification
REQ-032 Push 0x00000005, 0x0000000A; then act 0x00000005, 0x0000000A -> match_cnt=2, err_cnt=0, status=PASS, err never high.
REQ-033 Push 0x00000001; act 0x00000002 -> err pulses 1 cycle after compare, err_cnt=1, status=FAIL, fail_exp=0x1, fail_act=0x2; later mismatch 0x3/0x4 leaves capture unchanged.
REQ-034 DEPTH=4: push 5 words with no pops -> level=4, ovf=1, fifth word dropped; pushing at full with a concurrent pop -> ovf unchanged, level=4.
REQ-035 act_valid=1 on empty queue with concurrent push of 0x7 -> unf=1, counters 0, level=1; next act 0x7 -> match_cnt=1.
REQ-036 CNTWIDTH=4: 17 matching compares -> match_cnt holds 0xF.
REQ-037 Assert rst=0 with 3 words queued and a mismatch in flight -> all outputs at reset values, no err pulse after release, status=IDLE.
